// File: rtl/ysyx_22051013_booth_mul_multi.sv
// Iterative radix-4 Booth multiplier retiring STEPS_PER_CYCLE groups per clock, RV64 MUL* / MULW.
// Define YSYX_22051013_MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier is all-0/all-1.
module ysyx_22051013_booth_mul_multi #(
    parameter int XLEN            = 64,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic [1:0]      mul_signed,
    input  logic            mulw,
    input  logic [XLEN-1:0] mult_op1,
    input  logic [XLEN-1:0] mult_op2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result_hi,
    output logic [XLEN-1:0] result_lo,
    output logic            busy
);
    // Handshakes: a request moves on an edge with in_valid & in_ready & ~flush; a result moves on an
    // edge with out_valid & out_ready. Neither ready depends on the partner's valid.
    localparam int AW = 2 * XLEN + 4;
    localparam int MW = XLEN + 3;
    localparam int EW = XLEN + 2;
    localparam int NG = XLEN / 2 + 1;
    localparam int CW = $clog2(NG + 1);
    localparam int S  = STEPS_PER_CYCLE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   mcand_q, mcand_d;
    logic [MW-1:0]   mplier_q, mplier_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   grp_q, grp_d;
    logic            mulw_q, mulw_d;

    logic [XLEN-1:0] op1_w, op2_w;
    logic [EW-1:0]   op1_ext, op2_ext;
    logic [AW-1:0]   m_v, a_v;
    logic [MW-1:0]   q_v;
    logic            last_grp;
    logic            calc_done;

    always_comb begin
        op1_w   = mulw ? XLEN'($signed(mult_op1[31:0])) : mult_op1;
        op2_w   = mulw ? XLEN'($signed(mult_op2[31:0])) : mult_op2;
        op1_ext = {{2{mul_signed[0] & op1_w[XLEN-1]}}, op1_w};
        op2_ext = {{2{mul_signed[1] & op2_w[XLEN-1]}}, op2_w};
    end

    // Up to S Booth groups per clock; groups beyond the remaining count are skipped.
    always_comb begin
        m_v = mcand_q;
        q_v = mplier_q;
        a_v = acc_q;
        for (int i = 0; i < S; i++) begin
            if (i < int'(grp_q)) begin
                case (q_v[2:0])
                    3'b001, 3'b010: a_v = a_v + m_v;
                    3'b011:         a_v = a_v + {m_v[AW-2:0], 1'b0};
                    3'b100:         a_v = a_v + ~{m_v[AW-2:0], 1'b0} + AW'(1);
                    3'b101, 3'b110: a_v = a_v + ~m_v + AW'(1);
                    default:        a_v = a_v;
                endcase
                m_v = {m_v[AW-3:0], 2'b00};
                q_v = {{2{q_v[MW-1]}}, q_v[MW-1:2]};
            end
        end
    end

    assign last_grp = (grp_q <= CW'(S));

`ifdef YSYX_22051013_MUL_EARLY_TERM_EN
    assign calc_done = last_grp || (q_v == '0) || (q_v == '1);
`else
    assign calc_done = last_grp;
`endif

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        grp_d    = grp_q;
        mulw_d   = mulw_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = CALC;
                    mcand_d  = {{(XLEN + 2){op1_ext[EW-1]}}, op1_ext};
                    mplier_d = {op2_ext, 1'b0};
                    acc_d    = '0;
                    grp_d    = CW'(NG);
                    mulw_d   = mulw;
                end
            end
            CALC: begin
                mcand_d  = m_v;
                mplier_d = q_v;
                acc_d    = a_v;
                grp_d    = last_grp ? '0 : grp_q - CW'(S);
                if (calc_done) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Flush overrides everything, including an accept attempted in the same cycle.
        if (flush) begin
            state_d = IDLE;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            grp_q    <= '0;
            mulw_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            grp_q    <= grp_d;
            mulw_q   <= mulw_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !flush;
    assign out_valid = (state_q == DONE) && !flush;
    assign busy      = (state_q != IDLE);
    assign result_hi = out_valid ? acc_q[2*XLEN-1:XLEN] : '0;
    assign result_lo = out_valid ? (mulw_q ? XLEN'($signed(acc_q[31:0])) : acc_q[XLEN-1:0]) : '0;

endmodule

// File: tb/tb_ysyx_22051013_booth_mul_multi.sv
// Bench for ysyx_22051013_booth_mul_multi: S=1 and S=4 instances share stimulus, scoreboard per instance.
module tb_ysyx_22051013_booth_mul_multi;
  localparam int XLEN = 64;
  localparam int NG   = XLEN / 2 + 1;

  typedef struct {
    logic [63:0] hi;
    logic [63:0] lo;
    int          acc_cyc;
    int          lat0;
    int          lat1;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  mul_signed = 2'b00;
  logic        mulw = 1'b0;
  logic [63:0] op1 = '0;
  logic [63:0] op2 = '0;
  logic        out_ready = 1'b0;
  logic        in_ready0, out_valid0, busy0;
  logic        in_ready1, out_valid1, busy1;
  logic [63:0] hi0, lo0, hi1, lo1;

  ysyx_22051013_booth_mul_multi #(.XLEN(XLEN), .STEPS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .flush(flush),
    .mul_signed(mul_signed), .mulw(mulw), .mult_op1(op1), .mult_op2(op2),
    .out_valid(out_valid0), .out_ready(out_ready), .result_hi(hi0), .result_lo(lo0), .busy(busy0)
  );

  ysyx_22051013_booth_mul_multi #(.XLEN(XLEN), .STEPS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .flush(flush),
    .mul_signed(mul_signed), .mulw(mulw), .mult_op1(op1), .mult_op2(op2),
    .out_valid(out_valid1), .out_ready(out_ready), .result_hi(hi1), .result_lo(lo1), .busy(busy1)
  );

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   hold_ready = 1'b0;
  bit   seen[2];
  exp_t q0[$];
  exp_t q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: plain arithmetic on extended operands
  function automatic int lat_of(input int s, input logic [65:0] bx);
    int c_max;
    int g;
    logic signed [65:0] v;
    c_max = (NG + s - 1) / s;
`ifdef YSYX_22051013_MUL_EARLY_TERM_EN
    for (int c = 1; c < c_max; c++) begin
      g = c * s;
      v = $signed(bx) >>> (2 * g - 1);
      if (v == '0 || v == '1) return c;
    end
`endif
    g = 0;
    v = '0;
    return c_max;
  endfunction

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [1:0] sg, input logic w);
    exp_t e;
    logic [63:0] aw, bw;
    logic [129:0] ax, bx, p;
    aw = w ? {{32{a[31]}}, a[31:0]} : a;
    bw = w ? {{32{b[31]}}, b[31:0]} : b;
    ax = sg[0] ? {{66{aw[63]}}, aw} : {66'b0, aw};
    bx = sg[1] ? {{66{bw[63]}}, bw} : {66'b0, bw};
    p = ax * bx;
    e.hi = p[127:64];
    e.lo = w ? {{32{p[31]}}, p[31:0]} : p[63:0];
    e.acc_cyc = 0;
    e.lat0 = lat_of(1, bx[65:0]);
    e.lat1 = lat_of(4, bx[65:0]);
    return e;
  endfunction

  // scoreboard monitor
  task automatic mon(input int k, input logic ov, input logic [63:0] hi, input logic [63:0] lo);
    exp_t e;
    int   qs;
    qs = (k == 0) ? q0.size() : q1.size();
    if (!ov) begin
      chk($sformatf("idle_zero%0d", k), {hi, lo}, 128'd0);
    end else if (qs == 0) begin
      chk($sformatf("spurious_valid%0d", k), ov, 1'b0);
    end else begin
      e = (k == 0) ? q0[0] : q1[0];
      chk($sformatf("result%0d", k), {hi, lo}, {e.hi, e.lo});
      if (!seen[k]) begin
        chk($sformatf("latency%0d", k), cyc - e.acc_cyc, (k == 0) ? e.lat0 : e.lat1);
        seen[k] = 1'b1;
      end
      if (out_ready) begin
        if (k == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
        seen[k] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, out_valid0, hi0, lo0);
      mon(1, out_valid1, hi1, lo1);
    end
  end

  task automatic clear_sb();
    q0.delete();
    q1.delete();
    seen[0] = 1'b0;
    seen[1] = 1'b0;
  endtask

  // driver tasks
  task automatic wait_idle();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      chk("drain_timeout", q0.size() + q1.size(), 0);
      clear_sb();
    end
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sg, input logic w);
    exp_t e;
    wait_idle();
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    op1 = a;
    op2 = b;
    mul_signed = sg;
    mulw = w;
    @(negedge clk);
    chk("in_ready_idle0", in_ready0, 1'b1);
    chk("in_ready_idle1", in_ready1, 1'b1);
    e = model(a, b, sg, w);
    e.acc_cyc = cyc + 1;
    q0.push_back(e);
    q1.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op1 = {$urandom(), $urandom()};
    op2 = {$urandom(), $urandom()};
    mul_signed = 2'($urandom_range(0, 3));
    mulw = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [63:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'd1;
      3: return {32'd0, $urandom()};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  logic [63:0] da [7];
  logic [63:0] db [7];
  logic [1:0]  ds [7];
  logic        dw [7];

  initial begin
    da[0] = '1;                    db[0] = 64'd2;                 ds[0] = 2'b00; dw[0] = 1'b0;
    da[1] = '1;                    db[1] = '1;                    ds[1] = 2'b11; dw[1] = 1'b0;
    da[2] = 64'hFFFF_FFFF_FFFF_FFFE; db[2] = '1;                  ds[2] = 2'b01; dw[2] = 1'b0;
    da[3] = 64'hDEAD_BEEF_7FFF_FFFF; db[3] = 64'hDEAD_BEEF_0000_0002; ds[3] = 2'b11; dw[3] = 1'b1;
    da[4] = 64'd3;                 db[4] = 64'd5;                 ds[4] = 2'b00; dw[4] = 1'b0;
    da[5] = 64'h8000_0000_0000_0000; db[5] = 64'h8000_0000_0000_0000; ds[5] = 2'b11; dw[5] = 1'b0;
    da[6] = 64'h1234_5678_9ABC_DEF0; db[6] = 64'd0;                ds[6] = 2'b10; dw[6] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready0", in_ready0, 1'b1);
    chk("rst_out_valid0", out_valid0, 1'b0);
    chk("rst_busy0", busy0, 1'b0);
    chk("rst_result0", {hi0, lo0}, 128'd0);
    chk("rst_in_ready1", in_ready1, 1'b1);
    chk("rst_busy1", busy1, 1'b0);

    for (int i = 0; i < 7; i++) issue(da[i], db[i], ds[i], dw[i]);

    // consumer stall: result must hold while out_ready stays low
    issue(64'd3, 64'd5, 2'b00, 1'b0);
    hold_ready = 1'b1;
    begin
      int n = 0;
      while (!out_valid0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("stall_wait_valid", out_valid0, 1'b1);
    end
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready0, 1'b0);
      chk("stall_out_valid", out_valid0, 1'b1);
      chk("stall_busy", busy0, 1'b1);
    end
    hold_ready = 1'b0;

    // flush mid-calculation, with a request offered in the flush cycle
    issue({$urandom(), $urandom()}, {1'b1, 31'($urandom()), $urandom()}, 2'b00, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("flush_out_valid0", out_valid0, 1'b0);
    chk("flush_in_ready0", in_ready0, 1'b0);
    chk("flush_out_valid1", out_valid1, 1'b0);
    chk("flush_in_ready1", in_ready1, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    clear_sb();
    @(negedge clk);
    chk("post_flush_busy0", busy0, 1'b0);
    chk("post_flush_busy1", busy1, 1'b0);
    chk("post_flush_in_ready0", in_ready0, 1'b1);
    issue(64'd3, 64'd5, 2'b00, 1'b0);

    // reset in the middle of a calculation
    issue({$urandom(), $urandom()}, {1'b1, 31'($urandom()), $urandom()}, 2'b11, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_sb();
    @(negedge clk);
    chk("mid_rst_busy0", busy0, 1'b0);
    chk("mid_rst_out_valid0", out_valid0, 1'b0);
    chk("mid_rst_in_ready0", in_ready0, 1'b1);

    for (int i = 0; i < 40; i++)
      issue(rand_op(), rand_op(), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));

    wait_idle();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #800000;
    fails++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
